fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one FIFO write port (winc/wdata/wfull) among NREQ requesters, all in the write clock domain. It grants one requester at a time for a burst of up to BURST words, or until that requester's packet end. It then rotates priority to the next requester. It sits between the producer agents and the FIFO top level, and drives winc/wdata directly.

---
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets NREQ write-domain producers
// share one FIFO write port (winc/wdata/wfull).
// A grant lasts until the owner's packet ends, its BURST-word budget is used
// up, or it stops presenting data. Priority then rotates to the next requester.
// Optional build macro FIFO_WR_ARB_PRIO0_EN: requester 0 wins every
// arbitration in which it is valid, and its grants leave the rotation
// pointer untouched.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic [NREQ-1:0]         grant,
    output logic                    busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (BURST > 0) ? $clog2(BURST + 1) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
    localparam logic [PW-1:0] LAST_IDX  = PW'(NREQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [BW-1:0]   beat_cnt;

    logic [PW-1:0]   pick;
    logic            pick_vld;
    logic [PW-1:0]   idx;
    logic            own_vld;
    logic            own_last;
    logic            xfer;
    logic            release_c;
    logic [PW-1:0]   next_ptr;

    // Choose the first valid requester, searching cyclically from rr_ptr
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (!pick_vld && req_valid[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (req_valid[0]) begin
            pick     = '0;
            pick_vld = 1'b1;
        end
`endif
    end

    // Steer the owner's word to the FIFO and decide whether the grant ends
    always_comb begin
        own_vld   = req_valid[owner];
        own_last  = req_last[owner];
        wdata     = req_data[owner*DSIZE +: DSIZE];
        xfer      = busy & own_vld & ~wfull;
        winc      = xfer;
        req_ready = grant & {NREQ{~wfull}};
        // An idle owner gives up the port; a stalled owner (wfull) keeps it.
        release_c = ~own_vld | (xfer & (own_last | (beat_cnt == LAST_BEAT)));
        next_ptr  = (owner == LAST_IDX) ? '0 : owner + PW'(1);
    end

    // Arbitration FSM: IDLE picks an owner, GRANT streams its words
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant    <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        owner    <= pick;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        grant    <= '0;
                        busy     <= 1'b0;
                        beat_cnt <= '0;
                        state    <= IDLE;
`ifdef FIFO_WR_ARB_PRIO0_EN
                        if (owner != '0) begin
                            rr_ptr <= next_ptr;
                        end
`else
                        rr_ptr <= next_ptr;
`endif
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A write must never be issued into a full FIFO
    a_no_write_when_full: assert property (@(posedge wclk) disable iff (!wrst_n)
        !(winc && wfull));

    // At most one requester owns the port
    a_grant_onehot0: assert property (@(posedge wclk) disable iff (!wrst_n)
        $onehot0(grant));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester word queues act as producers, the
// bench acts as the FIFO, and an integer-level model predicts ownership.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;

    logic                  wclk = 1'b0;
    logic                  wrst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       grant;
    logic                  busy;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant),
        .busy      (busy)
    );

    // producer queues: word, last flag, idle gap before the word
    logic [DSIZE-1:0] qd [NREQ][$];
    bit               ql [NREQ][$];
    int               qg [NREQ][$];
    int               gapc [NREQ];

    // reference model state
    int m_owner = -1;
    int m_rr    = 0;
    int m_beats = 0;

    int ntot = 0;
    int npass = 0;
    bit chk_on = 0;
    int nwr_dut = 0;
    int nwr_model = 0;

    int order_log[$];
    int len_log[$];
    logic [NREQ-1:0] prev_grant = '0;
    int cur_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_list(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_count"}, got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++)
            chk(tag, got[k], exp[k]);
    endtask

    task automatic push(input int r, input int n, input bit last_end, input int gap_first);
        for (int k = 0; k < n; k++) begin
            logic [DSIZE-1:0] w;
            logic [7:0] rid;
            rid = 8'(r);
            w = {rid[1:0], 6'($urandom)};
            if (qd[r].size() == 0) gapc[r] = (k == 0) ? gap_first : 0;
            qd[r].push_back(w);
            ql[r].push_back(last_end && (k == n - 1));
            qg[r].push_back((k == 0) ? gap_first : 0);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++)
            if (qd[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_logs();
        order_log.delete();
        len_log.delete();
    endtask

    // One clock cycle: drive producers, check outputs at negedge, advance model
    task automatic cycles(input int n);
        for (int c = 0; c < n; c++) begin
            logic [NREQ-1:0] v, l, eg, er;
            logic eb, ew;
            int o, pick;
            v = '0; l = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (qd[i].size() > 0 && gapc[i] == 0) begin
                    v[i] = 1'b1;
                    l[i] = ql[i][0];
                    req_data[i*DSIZE +: DSIZE] = qd[i][0];
                end
            end
            req_valid = v;
            req_last  = l;
            @(negedge wclk);
            o = m_owner;
            eg = '0; er = '0; eb = 1'b0; ew = 1'b0;
            if (o >= 0) begin
                eg[o] = 1'b1;
                eb = 1'b1;
                ew = v[o] & ~wfull;
                if (!wfull) er[o] = 1'b1;
            end
            if (chk_on) begin
                chk("grant", 32'(grant), 32'(eg));
                chk("busy", 32'(busy), 32'(eb));
                chk("req_ready", 32'(req_ready), 32'(er));
                chk("winc", 32'(winc), 32'(ew));
                if (ew) chk("wdata", 32'(wdata), 32'(qd[o][0]));
            end
            // DUT-side event log (grant owners and words per grant)
            if (grant != '0 && prev_grant == '0) begin
                for (int i = 0; i < NREQ; i++) if (grant[i]) order_log.push_back(i);
                cur_len = 0;
            end
            if (winc === 1'b1) begin
                nwr_dut++;
                cur_len++;
            end
            if (grant == '0 && prev_grant != '0) len_log.push_back(cur_len);
            prev_grant = grant;
            // producers
            for (int i = 0; i < NREQ; i++)
                if (!v[i] && qd[i].size() > 0 && gapc[i] > 0) gapc[i]--;
            if (ew) begin
                nwr_model++;
                void'(qd[o].pop_front());
                void'(ql[o].pop_front());
                void'(qg[o].pop_front());
                if (qd[o].size() > 0) gapc[o] = qg[o][0];
            end
            // model
            if (!wrst_n) begin
                m_owner = -1; m_rr = 0; m_beats = 0;
            end else if (o < 0) begin
                pick = -1;
`ifdef FIFO_WR_ARB_PRIO0_EN
                if (v[0]) pick = 0;
`endif
                for (int k = 0; k < NREQ; k++)
                    if (pick < 0 && v[(m_rr + k) % NREQ]) pick = (m_rr + k) % NREQ;
                if (pick >= 0) begin
                    m_owner = pick;
                    m_beats = 0;
                end
            end else if (!v[o] || (ew && (l[o] || m_beats == BURST - 1))) begin
`ifdef FIFO_WR_ARB_PRIO0_EN
                if (o != 0) m_rr = (o + 1) % NREQ;
`else
                m_rr = (o + 1) % NREQ;
`endif
                m_owner = -1;
            end else if (ew) begin
                m_beats++;
            end
            @(posedge wclk);
            #1;
        end
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        cycles(1);
        wrst_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        int e[$];
        wrst_n = 1'b0; wfull = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < NREQ; i++) gapc[i] = 0;
        cycles(2);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk_on = 1;
        wrst_n = 1'b1;
        clear_logs();

        // single 3-word packet, then rr_ptr=1 shows as requester 1 winning
        push(0, 3, 1, 0);
        cycles(8);
        push(0, 1, 1, 0);
        push(1, 1, 1, 0);
        cycles(8);
        e = '{0, 1, 0}; chk_list("t1_order", order_log, e);
        e = '{3, 1, 1}; chk_list("t1_len", len_log, e);

        // four long packets: rotation 0,1,2,3 with full bursts
        do_reset();
        for (int r = 0; r < NREQ; r++) push(r, 8, 0, 0);
        cycles(50);
        e = '{0, 1, 2, 3, 0, 1, 2, 3}; chk_list("t2_order", order_log, e);
        e = '{4, 4, 4, 4, 4, 4, 4, 4}; chk_list("t2_len", len_log, e);

        // wfull stall mid-burst on requester 2
        do_reset();
        push(2, 8, 0, 0);
        cycles(3);
        wfull = 1'b1;
        cycles(5);
        chk("t3_stall_grant", 32'(grant), 32'h4);
        wfull = 1'b0;
        cycles(15);
        e = '{2, 2}; chk_list("t3_order", order_log, e);
        e = '{4, 4}; chk_list("t3_len", len_log, e);

        // owner 1 goes idle after two words; requester 2 is next
        do_reset();
        push(0, 1, 1, 0);
        cycles(4);
        push(1, 2, 0, 0);
        push(1, 1, 1, 2);
        push(2, 3, 1, 0);
        cycles(20);
        e = '{0, 1, 2, 1}; chk_list("t4_order", order_log, e);
        e = '{1, 2, 3, 1}; chk_list("t4_len", len_log, e);

        // last coincides with the 4th beat: one rotation only
        do_reset();
        push(0, 4, 1, 0);
        cycles(7);
        push(1, 1, 1, 0);
        push(2, 1, 1, 0);
        cycles(8);
        e = '{0, 1, 2}; chk_list("t5_order", order_log, e);
        e = '{4, 1, 1}; chk_list("t5_len", len_log, e);
        // reset in the middle of a burst
        push(3, 8, 0, 0);
        cycles(3);
        wrst_n = 1'b0;
        cycles(1);
        chk("t5_rst_grant", 32'(grant), 32'd0);
        chk("t5_rst_winc", 32'(winc), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        wrst_n = 1'b1;
        cycles(20);

        // requesters 0 and 3 contend with the pointer parked on 3
        do_reset();
        push(2, 1, 1, 0);
        cycles(4);
        for (int k = 0; k < 4; k++) begin
            push(0, 1, 1, 0);
            push(3, 1, 1, 0);
        end
        cycles(30);
`ifdef FIFO_WR_ARB_PRIO0_EN
        e = '{2, 0, 0, 0, 0, 3, 3, 3, 3};
`else
        e = '{2, 3, 0, 3, 0, 3, 0, 3, 0};
`endif
        chk_list("t6_order", order_log, e);

        // randomized traffic with wfull noise and occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < NREQ; r++)
                if (qd[r].size() < 3 && ($urandom % 4) == 0)
                    push(r, int'($urandom_range(1, 6)), ($urandom % 4) != 0, int'($urandom_range(0, 3)));
            wfull  = (($urandom % 4) == 0);
            wrst_n = (($urandom % 250) != 0);
            cycles(1);
        end
        wrst_n = 1'b1;
        wfull  = 1'b0;
        for (int k = 0; k < 400 && !all_empty(); k++) cycles(1);
        chk("drained", 32'(all_empty()), 32'd1);
        chk("nwrites", nwr_dut, nwr_model);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
